// File: rtl/inst_enc_pkg.sv
// Shared definitions for the RV32I instruction encoder.
//   FMT_*      : format codes carried on in_fmt
//   OP_*       : base opcodes the encoder cares about
//   NOP_INST   : word emitted when a transaction is in error
//   IMM*_MIN/MAX, SHAMT_MAX : legal immediate ranges per format
//   enc_fields_t : one decoded transaction as held in stage 1
package inst_enc_pkg;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;
  localparam int SHAMT_MAX = 31;
  localparam int IMM13_MIN = -4096;
  localparam int IMM13_MAX = 4094;
  localparam int IMM21_MIN = -1048576;
  localparam int IMM21_MAX = 1048574;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } enc_fields_t;

  function automatic logic imm_in_range(input logic [31:0] imm, input int lo, input int hi);
    return ($signed(imm) >= lo) && ($signed(imm) <= hi);
  endfunction

endpackage

// File: rtl/inst_field_pack.sv
// Combinational packer: one decoded transaction in, one RV32I word out.
//   fields_i : format, opcode, register indices, funct3/7 and signed immediate
//   inst_o   : packed instruction, or NOP_INST when err_o is set
//   err_o    : immediate out of range for the format, or illegal format code
module inst_field_pack
  import inst_enc_pkg::*;
(
  input  enc_fields_t fields_i,
  output logic [31:0] inst_o,
  output logic        err_o
);

  logic [31:0] raw;
  logic        err;
  logic        is_shift;
  logic [31:0] imm;

  assign imm = fields_i.imm;

  // Shift-immediates reuse funct7 and only carry a 5-bit shamt
  assign is_shift = (fields_i.opcode == OP_IMM) &&
                    ((fields_i.funct3 == 3'b001) || (fields_i.funct3 == 3'b101));

  always_comb begin
    raw = 32'h0;
    err = 1'b0;
    unique case (fields_i.fmt)
      FMT_R: begin
        raw = {fields_i.funct7, fields_i.rs2, fields_i.rs1, fields_i.funct3,
               fields_i.rd, fields_i.opcode};
      end
      FMT_I: begin
        if (is_shift) begin
          raw = {fields_i.funct7, imm[4:0], fields_i.rs1, fields_i.funct3,
                 fields_i.rd, fields_i.opcode};
          err = !imm_in_range(imm, 0, SHAMT_MAX);
        end else begin
          raw = {imm[11:0], fields_i.rs1, fields_i.funct3, fields_i.rd, fields_i.opcode};
          err = !imm_in_range(imm, IMM12_MIN, IMM12_MAX);
        end
      end
      FMT_S: begin
        raw = {imm[11:5], fields_i.rs2, fields_i.rs1, fields_i.funct3,
               imm[4:0], fields_i.opcode};
        err = !imm_in_range(imm, IMM12_MIN, IMM12_MAX);
      end
      FMT_B: begin
        raw = {imm[12], imm[10:5], fields_i.rs2, fields_i.rs1, fields_i.funct3,
               imm[4:1], imm[11], fields_i.opcode};
        err = !imm_in_range(imm, IMM13_MIN, IMM13_MAX) || imm[0];
      end
      FMT_U: begin
        raw = {imm[31:12], fields_i.rd, fields_i.opcode};
        err = |imm[11:0];
      end
      FMT_J: begin
        raw = {imm[20], imm[10:1], imm[11], imm[19:12], fields_i.rd, fields_i.opcode};
        err = !imm_in_range(imm, IMM21_MIN, IMM21_MAX) || imm[0];
      end
      default: begin
        err = 1'b1;
      end
    endcase
  end

  assign inst_o = err ? NOP_INST : raw;
  assign err_o  = err;

endmodule

// File: rtl/inst_encoder.sv
// Two-stage valid/ready RV32I instruction encoder with write-address counter.
//   clk, rst_n      : clock, async active-low reset
//   clr             : synchronous flush of both stages and address restart
//   in_valid/ready  : input handshake; in_* carry the decoded fields
//   out_valid/ready : output handshake
//   out_inst        : encoded word (NOP on error)
//   out_addr        : byte address of out_inst, steps by 4, wraps at 2^ADDR_W
//   out_err         : word was in error
// ADDR_W must be at least 3; BASE_ADDR must be a multiple of 4.
module inst_encoder
  import inst_enc_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(4);

  enc_fields_t       in_fields;
  logic              s1_valid_q, s1_valid_d;
  enc_fields_t       s1_fields_q, s1_fields_d;
  logic              s2_valid_q, s2_valid_d;
  logic [31:0]       s2_inst_q, s2_inst_d;
  logic              s2_err_q, s2_err_d;
  logic [ADDR_W-1:0] s2_addr_q, s2_addr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [31:0]       pack_inst;
  logic              pack_err;
  logic              s1_rdy, s2_rdy;

  assign in_fields = '{fmt: in_fmt, opcode: in_opcode, rd: in_rd, rs1: in_rs1,
                       rs2: in_rs2, funct3: in_funct3, funct7: in_funct7, imm: in_imm};

  inst_field_pack u_pack (
    .fields_i (s1_fields_q),
    .inst_o   (pack_inst),
    .err_o    (pack_err)
  );

  assign s2_rdy   = !s2_valid_q || out_ready;
  assign s1_rdy   = !s1_valid_q || s2_rdy;
  assign in_ready = s1_rdy;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_fields_d = s1_fields_q;
    s2_valid_d  = s2_valid_q;
    s2_inst_d   = s2_inst_q;
    s2_err_d    = s2_err_q;
    s2_addr_d   = s2_addr_q;
    cnt_d       = cnt_q;

    if (s1_rdy) begin
      s1_valid_d = in_valid;
      if (in_valid) s1_fields_d = in_fields;
    end

    // The address is bound when the word enters S2, so errored words keep their slot
    if (s2_rdy) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_inst_d = pack_inst;
        s2_err_d  = pack_err;
        s2_addr_d = cnt_q;
        cnt_d     = cnt_q + STEP;
      end
    end

    // clr wins over any same-cycle transfer; output data regs are left as-is
    if (clr) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
      cnt_d      = BASE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_fields_q <= '0;
      s2_valid_q  <= 1'b0;
      s2_inst_q   <= 32'h0;
      s2_err_q    <= 1'b0;
      s2_addr_q   <= BASE;
      cnt_q       <= BASE;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_fields_q <= s1_fields_d;
      s2_valid_q  <= s2_valid_d;
      s2_inst_q   <= s2_inst_d;
      s2_err_q    <= s2_err_d;
      s2_addr_q   <= s2_addr_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_inst  = s2_inst_q;
  assign out_err   = s2_err_q;
  assign out_addr  = s2_addr_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: directed vectors, stall, wrap, clr/reset
// and a randomized run checked against an arithmetic reference encoder.
module tb_inst_encoder;

  logic        clk, rst_n, clr;
  logic        in_valid, in_ready, out_valid, out_ready, out_err;
  logic [2:0]  in_fmt, in_funct3;
  logic [6:0]  in_opcode, in_funct7;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm, out_inst;
  logic [7:0]  out_addr;

  logic        in_ready4, out_valid4, out_err4;
  logic [31:0] out_inst4;
  logic [3:0]  out_addr4;

  int n_checks = 0;
  int n_fail   = 0;
  int n_out    = 0;

  logic [32:0] exp_q[$];
  logic [7:0]  exp_addr = 8'h00;
  logic        hold = 1'b0;
  logic [31:0] hold_inst;
  logic        hold_err;
  logic [7:0]  hold_addr;

  inst_encoder #(.ADDR_W(8), .BASE_ADDR(0)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_addr(out_addr), .out_err(out_err)
  );

  inst_encoder #(.ADDR_W(4), .BASE_ADDR(0)) dut4 (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready4),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid4), .out_ready(out_ready), .out_inst(out_inst4),
    .out_addr(out_addr4), .out_err(out_err4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference encoder built from field positions with shifts and masks.
  function automatic logic [32:0] ref_enc(input logic [2:0] fmt, input logic [6:0] op,
                                          input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2, input logic [2:0] f3,
                                          input logic [6:0] f7, input int imm);
    int unsigned u, w, o, d, r1, r2, g3, g7;
    bit ok, sh;
    u = $unsigned(imm);
    o = 32'(op); d = 32'(rd); r1 = 32'(rs1); r2 = 32'(rs2); g3 = 32'(f3); g7 = 32'(f7);
    sh = (op == 7'h13) && (f3 == 3'd1 || f3 == 3'd5);
    ok = 1'b0;
    w  = 0;
    case (fmt)
      3'd0: begin ok = 1'b1; w = o | d << 7 | g3 << 12 | r1 << 15 | r2 << 20 | g7 << 25; end
      3'd1: begin
        if (sh) begin
          ok = (imm >= 0) && (imm <= 31);
          w  = o | d << 7 | g3 << 12 | r1 << 15 | (u & 31) << 20 | g7 << 25;
        end else begin
          ok = (imm >= -2048) && (imm <= 2047);
          w  = o | d << 7 | g3 << 12 | r1 << 15 | (u & 4095) << 20;
        end
      end
      3'd2: begin
        ok = (imm >= -2048) && (imm <= 2047);
        w  = o | (u & 31) << 7 | g3 << 12 | r1 << 15 | r2 << 20 | ((u >> 5) & 127) << 25;
      end
      3'd3: begin
        ok = (imm >= -4096) && (imm <= 4094) && (imm % 2 == 0);
        w  = o | ((u >> 11) & 1) << 7 | ((u >> 1) & 15) << 8 | g3 << 12 | r1 << 15 |
             r2 << 20 | ((u >> 5) & 63) << 25 | ((u >> 12) & 1) << 31;
      end
      3'd4: begin ok = (u % 4096) == 0; w = o | d << 7 | (u - (u % 4096)); end
      3'd5: begin
        ok = (imm >= -1048576) && (imm <= 1048574) && (imm % 2 == 0);
        w  = o | d << 7 | ((u >> 12) & 255) << 12 | ((u >> 11) & 1) << 20 |
             ((u >> 1) & 1023) << 21 | ((u >> 20) & 1) << 31;
      end
      default: ok = 1'b0;
    endcase
    if (!ok) w = 32'h13;
    return {!ok, w};
  endfunction

  function automatic int rand_imm();
    case ($urandom_range(0, 5))
      0: return int'($urandom_range(0, 63)) - 32;
      1: case ($urandom_range(0, 11))
           0: return -2048;   1: return 2047;    2: return 2048;   3: return -2049;
           4: return -4096;   5: return 4094;    6: return 4095;   7: return -4098;
           8: return 1048574; 9: return -1048576; 10: return 1048576; default: return 32;
         endcase
      2: return int'($urandom);
      3: return int'($urandom & 32'hFFFF_F000);
      4: return int'($urandom_range(0, 8191)) - 4096;
      default: return int'($urandom_range(0, 2097151)) - 1048576;
    endcase
  endfunction

  task automatic set_fields(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                            input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                            input logic [6:0] f7, input int imm);
    in_fmt = fmt; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = $unsigned(imm);
  endtask

  task automatic set_random_fields();
    logic [6:0] op;
    op = ($urandom_range(0, 1) == 0) ? 7'h13 : 7'($urandom);
    set_fields(3'($urandom), op, 5'($urandom), 5'($urandom), 5'($urandom),
               3'($urandom), 7'($urandom), rand_imm());
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
  endtask

  // Scoreboard: transfers are decided at the negedge before the edge that performs them.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete(); exp_addr = 8'h00; hold = 1'b0;
    end else begin
      if (hold) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_inst !== hold_inst || out_err !== hold_err ||
            out_addr !== hold_addr) begin
          n_fail++;
          $display("FAIL hold_stable: got v=%b inst=%h err=%b addr=%h, want v=1 inst=%h err=%b addr=%h",
                   out_valid, out_inst, out_err, out_addr, hold_inst, hold_err, hold_addr);
        end
      end
      if (clr) begin
        exp_q.delete(); exp_addr = 8'h00; hold = 1'b0;
      end else begin
        if (out_valid && out_ready) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL out_word: got inst=%h addr=%h with no word expected", out_inst, out_addr);
          end else begin
            logic [32:0] e;
            e = exp_q.pop_front();
            if (out_err !== e[32] || out_inst !== e[31:0] || out_addr !== exp_addr) begin
              n_fail++;
              $display("FAIL out_word: got inst=%h err=%b addr=%h, want inst=%h err=%b addr=%h",
                       out_inst, out_err, out_addr, e[31:0], e[32], exp_addr);
            end
          end
          exp_addr = exp_addr + 8'd4;
          n_out++;
        end
        if (in_valid && in_ready)
          exp_q.push_back(ref_enc(in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3,
                                  in_funct7, $signed(in_imm)));
        hold      = out_valid && !out_ready;
        hold_inst = out_inst;
        hold_err  = out_err;
        hold_addr = out_addr;
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_fields(3'd0, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 0);
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_inst !== 32'h0 || out_err !== 1'b0 || out_addr !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b inst=%h err=%b addr=%h, want 0/0/0/00",
               out_valid, out_inst, out_err, out_addr);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready: got in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
    end
  endtask

  typedef struct {
    bit          clr_first;
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    int          imm;
    logic [31:0] inst;
    logic        err;
    logic [7:0]  addr;
  } dvec_t;

  task automatic test_directed();
    dvec_t v[$];
    v.push_back('{0, 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, -1,          32'hFFF00093, 1'b0, 8'h00});
    v.push_back('{1, 3'd2, 7'h23, 5'd0, 5'd2, 5'd5, 3'd2, 7'h00, 8,           32'h00512423, 1'b0, 8'h00});
    v.push_back('{0, 3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, -4,          32'hFE000EE3, 1'b0, 8'h04});
    v.push_back('{0, 3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 2048,        32'h001000EF, 1'b0, 8'h08});
    v.push_back('{0, 3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 3,           32'h00000013, 1'b1, 8'h0C});
    v.push_back('{0, 3'd1, 7'h13, 5'd3, 5'd4, 5'd0, 3'd5, 7'h20, 7,           32'h40725193, 1'b0, 8'h10});
    v.push_back('{0, 3'd1, 7'h13, 5'd3, 5'd4, 5'd0, 3'd5, 7'h20, 32,          32'h00000013, 1'b1, 8'h14});
    v.push_back('{0, 3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345000, 32'h123452B7, 1'b0, 8'h18});
    v.push_back('{0, 3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345001, 32'h00000013, 1'b1, 8'h1C});
    v.push_back('{0, 3'd6, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'h00, 0,           32'h00000013, 1'b1, 8'h20});
    v.push_back('{0, 3'd0, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 12345,       32'h403100B3, 1'b0, 8'h24});
    v.push_back('{0, 3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 4094,        32'h7E000FE3, 1'b0, 8'h28});
    v.push_back('{0, 3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 4096,        32'h00000013, 1'b1, 8'h2C});
    v.push_back('{0, 3'd1, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 2047,        32'h7FF00013, 1'b0, 8'h30});
    v.push_back('{0, 3'd1, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, -2049,       32'h00000013, 1'b1, 8'h34});
    out_ready = 1'b1;
    foreach (v[i]) begin
      if (v[i].clr_first) pulse_clr();
      else begin @(posedge clk); #1; end
      set_fields(v[i].fmt, v[i].op, v[i].rd, v[i].rs1, v[i].rs2, v[i].f3, v[i].f7, v[i].imm);
      in_valid = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL directed_latency1[%0d]: got out_valid=%b, want 0", i, out_valid);
      end
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || out_inst !== v[i].inst || out_err !== v[i].err ||
          out_addr !== v[i].addr) begin
        n_fail++;
        $display("FAIL directed[%0d]: got v=%b inst=%h err=%b addr=%h, want v=1 inst=%h err=%b addr=%h",
                 i, out_valid, out_inst, out_err, out_addr, v[i].inst, v[i].err, v[i].addr);
      end
    end
  endtask

  task automatic test_stall();
    int idx = 0;
    int start_out;
    int cyc;
    logic [31:0] held;
    pulse_clr();
    out_ready = 1'b0;
    set_fields(3'd1, 7'h13, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 100);
    in_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      logic fire;
      @(negedge clk);
      fire = in_valid && in_ready;
      if (c == 2) held = out_inst;
      @(posedge clk); #1;
      if (fire) idx++;
      if (idx < 3) set_fields(3'd1, 7'h13, 5'(idx + 1), 5'd1, 5'd0, 3'd0, 7'd0, 100 + idx);
    end
    @(negedge clk);
    n_checks++;
    if (idx != 2 || in_ready !== 1'b0 || out_inst !== held) begin
      n_fail++;
      $display("FAIL stall_backpressure: got accepts=%0d in_ready=%b inst=%h, want 2/0/%h",
               idx, in_ready, out_inst, held);
    end
    start_out = n_out;
    out_ready = 1'b1;
    cyc = 0;
    while ((idx < 3 || n_out < start_out + 3) && cyc < 20) begin
      logic fire;
      @(negedge clk);
      fire = in_valid && in_ready;
      @(posedge clk); #1;
      if (fire) begin idx++; in_valid = 1'b0; end
      cyc++;
    end
    in_valid = 1'b0;
    n_checks++;
    if (n_out - start_out != 3) begin
      n_fail++;
      $display("FAIL stall_release: got %0d words out, want 3", n_out - start_out);
    end
  endtask

  task automatic test_wrap();
    int accepted = 0;
    int got = 0;
    logic [3:0] addrs[5];
    pulse_clr();
    out_ready = 1'b1;
    set_random_fields();
    in_valid = 1'b1;
    for (int c = 0; c < 15 && got < 5; c++) begin
      logic fire;
      @(negedge clk);
      fire = in_valid && in_ready;
      if (out_valid4 && out_ready) begin addrs[got] = out_addr4; got++; end
      @(posedge clk); #1;
      if (fire) accepted++;
      if (accepted >= 5) in_valid = 1'b0;
      else set_random_fields();
    end
    in_valid = 1'b0;
    n_checks++;
    if (got != 5) begin
      n_fail++;
      $display("FAIL wrap_count: got %0d words, want 5", got);
    end
    for (int i = 0; i < got; i++) begin
      logic [3:0] want;
      want = 4'((4 * i) % 16);
      n_checks++;
      if (addrs[i] !== want) begin
        n_fail++;
        $display("FAIL wrap_addr[%0d]: got %h, want %h", i, addrs[i], want);
      end
    end
  endtask

  task automatic test_clr_and_reset();
    int cyc;
    pulse_clr();
    out_ready = 1'b0;
    set_fields(3'd1, 7'h13, 5'd7, 5'd2, 5'd0, 3'd0, 7'd0, 55);
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1 clr = 1'b1;
    set_fields(3'd1, 7'h13, 5'd9, 5'd2, 5'd0, 3'd0, 7'd0, 66);
    @(posedge clk); #1 clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL clr_flush[%0d]: got out_valid=%b, want 0", c, out_valid);
      end
    end
    @(posedge clk); #1;
    set_fields(3'd1, 7'h13, 5'd4, 5'd2, 5'd0, 3'd0, 7'd0, 77);
    in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (out_valid !== 1'b1 && cyc < 10);
    n_checks++;
    if (out_valid !== 1'b1 || out_addr !== 8'h00) begin
      n_fail++;
      $display("FAIL clr_restart: got v=%b addr=%h, want 1/00", out_valid, out_addr);
    end
    @(posedge clk); #1 out_ready = 1'b0;
    set_fields(3'd2, 7'h23, 5'd0, 5'd3, 5'd4, 3'd2, 7'd0, 12);
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0; in_valid = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_inst !== 32'h0 || out_err !== 1'b0 || out_addr !== 8'h00) begin
      n_fail++;
      $display("FAIL async_reset: got v=%b inst=%h err=%b addr=%h, want 0/0/0/00",
               out_valid, out_inst, out_err, out_addr);
    end
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1; out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_no_partial: got out_valid=%b in_ready=%b, want 0/1", out_valid, in_ready);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      clr       = ($urandom_range(0, 63) == 0);
      set_random_fields();
    end
    @(posedge clk); #1 in_valid = 1'b0; clr = 1'b0; out_ready = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL random_drain: got %0d words left, out_valid=%b, want 0/0", exp_q.size(), out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_wrap();
    test_clr_and_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
